// File: rtl/uart_sync_fifo_if.sv
// rtl/uart_sync_fifo_if.sv - host/shifter-side bundle for the UART buffering FIFO
interface uart_sync_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic                     w_e;
    logic                     r_e;
    logic                     clr_err;
    logic [WIDTH-1:0]         data_in;
    logic [WIDTH-1:0]         data_out;
    logic                     empty;
    logic                     full;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output w_e, r_e, clr_err, data_in,
        input  data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  w_e, r_e, clr_err, data_in,
        output data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with occupancy thresholds, sticky errors, optional FWFT
module uart_sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input logic             clk,
    input logic             rst,
    uart_sync_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    w_ptr;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    occ;
    logic             is_empty;
    logic             is_full;
    logic             rd_ok;
    logic             wr_ok;
    logic             ovf_q;
    logic             unf_q;

    // Extra pointer bit distinguishes full from empty so all DEPTH slots are usable.
    assign is_empty = (w_ptr == r_ptr);
    assign is_full  = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
    assign occ      = w_ptr - r_ptr;

    assign rd_ok = bus.r_e && !is_empty;
    assign wr_ok = bus.w_e && (!is_full || rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[w_ptr[AW-1:0]] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    // A new error in the same cycle as clr_err must not be lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.w_e && !wr_ok) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end
            if (bus.r_e && is_empty) begin
                unf_q <= 1'b1;
            end else if (bus.clr_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = is_empty ? '0 : mem[r_ptr[AW-1:0]];
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem[r_ptr[AW-1:0]];
                end
            end
            assign bus.data_out = dout_q;
        end
    endgenerate

    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.count        = occ;
    assign bus.almost_full  = (occ >= AF_THR);
    assign bus.almost_empty = (occ <= AE_THR);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_uart_sync_fifo.sv
// tb/tb_uart_sync_fifo.sv - scoreboard bench driving standard and FWFT instances in lockstep
module tb_uart_sync_fifo;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int AE_LEVEL = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) b0 ();
    uart_sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) b1 ();

    uart_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(0))
        dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    uart_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(1))
        dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    typedef struct {
        int cnt;
        bit ovf;
        bit unf;
        int d0;
        int d1;
    } exp_t;

    exp_t sb[$];
    int   q[$];
    int   d0_reg = 0;
    bit   m_ovf  = 1'b0;
    bit   m_unf  = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference queue is advanced at the same edge as the DUTs.
    task automatic cyc(input bit rn, input bit w, input bit r, input bit c, input int d);
        exp_t e;
        bit   rd;
        bit   wr;
        bit   was_empty;
        @(negedge clk);
        rst        = rn;
        b0.w_e     = w;  b1.w_e     = w;
        b0.r_e     = r;  b1.r_e     = r;
        b0.clr_err = c;  b1.clr_err = c;
        b0.data_in = d[WIDTH-1:0];
        b1.data_in = d[WIDTH-1:0];
        @(posedge clk);
        if (!rn) begin
            q.delete();
            d0_reg = 0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            was_empty = (q.size() == 0);
            rd = r && !was_empty;
            wr = w && ((q.size() < DEPTH) || rd);
            if (rd) d0_reg = q.pop_front();
            if (wr) q.push_back(d & 'hFF);
            m_ovf = (w && !wr) || (m_ovf && !c);
            m_unf = (r && was_empty) || (m_unf && !c);
        end
        e.cnt = q.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        e.d0  = d0_reg;
        e.d1  = (q.size() > 0) ? q[0] : 0;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("count0",  32'(b0.count),        e.cnt);
                chk("count1",  32'(b1.count),        e.cnt);
                chk("empty0",  32'(b0.empty),        32'(e.cnt == 0));
                chk("empty1",  32'(b1.empty),        32'(e.cnt == 0));
                chk("full0",   32'(b0.full),         32'(e.cnt == DEPTH));
                chk("full1",   32'(b1.full),         32'(e.cnt == DEPTH));
                chk("afull0",  32'(b0.almost_full),  32'(e.cnt >= AF_LEVEL));
                chk("aempty0", 32'(b0.almost_empty), 32'(e.cnt <= AE_LEVEL));
                chk("afull1",  32'(b1.almost_full),  32'(e.cnt >= AF_LEVEL));
                chk("aempty1", 32'(b1.almost_empty), 32'(e.cnt <= AE_LEVEL));
                chk("ovf0",    32'(b0.overflow),     32'(e.ovf));
                chk("unf0",    32'(b0.underflow),    32'(e.unf));
                chk("ovf1",    32'(b1.overflow),     32'(e.ovf));
                chk("unf1",    32'(b1.underflow),    32'(e.unf));
                chk("dout_std",  32'(b0.data_out),   e.d0);
                chk("dout_fwft", 32'(b1.data_out),   e.d1);
            end
        end
    end

    initial begin : stimulus
        int w_pct;
        int r_pct;
        b0.w_e = 0; b0.r_e = 0; b0.clr_err = 0; b0.data_in = '0;
        b1.w_e = 0; b1.r_e = 0; b1.clr_err = 0; b1.data_in = '0;

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 0, pass * 16 + i);
            for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 0, 0);
            cyc(1, 0, 0, 0, 0);
        end

        for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 0, 'h40 + i);
        cyc(1, 1, 0, 0, 'hAA);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 'h55);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 0, 0);

        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 'h3C);
        cyc(1, 1, 1, 1, 'h3D);
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0);

        cyc(1, 1, 0, 0, 'hA5);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 'h5A);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 'h11);
        cyc(1, 1, 0, 0, 'h22);
        cyc(1, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 'h33);
        cyc(1, 0, 0, 0, 0);

        for (int ph = 0; ph < 8; ph++) begin
            w_pct = (ph % 2 == 0) ? 75 : 30;
            r_pct = (ph % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 250; i++) begin
                cyc(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 99) < w_pct),
                    ($urandom_range(0, 99) < r_pct),
                    ($urandom_range(0, 15) == 0),
                    int'($urandom_range(0, 255)));
            end
        end

        @(posedge clk);
        #2;
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_sync_fifo.md
Name: uart_sync_fifo

Overview:
Parametrised single-clock FIFO for UART TX/RX buffering. It is the next-generation replacement for the basic sequential memory buffer.
- Stores the full DEPTH entries, using extra-bit pointers.
- Provides occupancy count and programmable almost-full/almost-empty thresholds.
- Has sticky overflow/underflow error flags.
- Supports standard or first-word-fall-through (FWFT) read mode.
- Sits between the baud-rate TX/RX shifters and the host-side register interface.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of entries; power of two, >= 2
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = registered read with 1-cycle latency; 1 = first-word-fall-through

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
w_e  input  1  write request
r_e  input  1  read request (pop acknowledge in FWFT mode)
clr_err  input  1  clears sticky overflow/underflow flags
data_in  input  WIDTH  write data
data_out  output  WIDTH  read data
empty  output  1  no stored entries
full  output  1  DEPTH entries stored
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was refused
underflow  output  1  sticky: a read was refused

Behaviour:
- Pointers: w_ptr and r_ptr are $clog2(DEPTH)+1 bits wide; the low bits address memory and wrap naturally at DEPTH.
- empty = (w_ptr == r_ptr).
- full = (MSBs differ) and (low bits equal).
- count = w_ptr - r_ptr, modulo 2^($clog2(DEPTH)+1).
- All status outputs are combinational from the registered pointers and change the cycle after the accepted operation.
- Reset (rst=0 at a clock edge), including mid-operation:
  - w_ptr = r_ptr = 0; data_out = 0; overflow = underflow = 0.
  - Hence empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset and not guaranteed.
- rd_ok = r_e && !empty.
- wr_ok = w_e && (!full || rd_ok): a write is accepted while full only when a read is accepted in the same cycle.
- When empty there is no read bypass: w_e and r_e together store the word, refuse the read, and set underflow.
- A write stores data_in at mem[w_ptr low bits] and increments w_ptr.
- A read increments r_ptr.
- Simultaneous wr_ok and rd_ok leave count unchanged.
- FWFT=0:
  - On rd_ok, data_out <= mem[r_ptr] at that edge, so data is valid the cycle after r_e.
  - data_out otherwise holds its value, including on a refused read.
- FWFT=1:
  - data_out = mem[r_ptr] whenever !empty, and 0 when empty.
  - r_e pops the current head; the next word (or 0) appears the following cycle.
  - A word written into an empty FIFO is visible on data_out one cycle after the write edge.
- overflow is set on w_e && !wr_ok; underflow is set on r_e && empty.
- The flags stay set until clr_err=1 or reset. If a set condition and clr_err coincide, set wins.
- Refused operations never move the pointers or alter memory.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles, then release -> empty=1, full=0, count=0, data_out=0, almost_empty=1, overflow=underflow=0.
- Fill/wrap, DEPTH=16, FWFT=0: write 0x00..0x0F -> full=1, count=16; almost_full first asserts after the 12th write. Then read 16 times -> data_out = 0x00..0x0F, each one cycle after its r_e; empty=1. Repeat with 0x10..0x1F -> pointers wrap and order is preserved.
- Overflow: with the FIFO full, w_e=1 and r_e=0 with data_in=0xAA -> overflow=1, count stays 16, and 0xAA never appears on reads. Pulse clr_err -> overflow=0.
- Full simultaneous access: with the FIFO full, w_e=r_e=1 with data_in=0x55 -> count stays 16, the oldest word is read out, and 0x55 is read out last after 15 further reads.
- Empty read/underflow: with the FIFO empty, r_e=1 -> underflow=1 and data_out holds. With the FIFO empty, w_e=r_e=1 with 0x3C -> count=1 and underflow=1.
- FWFT=1: write 0xA5 into an empty FIFO -> data_out=0xA5 on the next cycle with no r_e. Write 0x5A, pulse r_e -> data_out=0x5A. Pulse r_e -> data_out=0, empty=1. Assert rst mid-sequence -> all outputs return to their reset values.
